// File: rtl/primus_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate selectors and the
// ID/EX pipeline-register layout.
package primus_pkg;

   localparam int DATA_W = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] rs1_data;
      logic [DATA_W-1:0] rs2_data;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rd;
      logic [2:0]        funct3;
      alu_op_e           alu_op;
      logic              alu_src_imm;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              branch;
      logic              jump;
      logic              illegal;
   } id_ex_t;

   // alt_sub selects SUB for funct3=000, alt_sra selects SRA for funct3=101.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                           input logic alt_sub,
                                           input logic alt_sra);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate
// from the raw instruction word.
module imm_gen
   import primus_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     ir_i,
   input  imm_sel_e        sel_i,
   output logic [XLEN-1:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (sel_i)
         IMM_I: imm_o = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
         IMM_S: imm_o = {{(XLEN-12){ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
         IMM_B: imm_o = {{(XLEN-13){ir_i[31]}}, ir_i[31], ir_i[7],
                         ir_i[30:25], ir_i[11:8], 1'b0};
         IMM_U: imm_o = {{(XLEN-32){ir_i[31]}}, ir_i[31:12], 12'h000};
         IMM_J: imm_o = {{(XLEN-21){ir_i[31]}}, ir_i[31], ir_i[19:12],
                         ir_i[20], ir_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched word, detects load-use hazards and
// holds the result in the ID/EX pipeline register.
module id_stage
   import primus_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [31:0]     ir_i,
   input  logic [XLEN-1:0] npc_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic            flush_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      ex_rd_i,
   input  logic            ex_is_load_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rd_o,
   output logic [2:0]      funct3_o,
   output logic [3:0]      alu_op_o,
   output logic            alu_src_imm_o,
   output logic            reg_write_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   output logic            branch_o,
   output logic            jump_o,
   output logic            illegal_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and a held valid keeps its data.

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   imm_sel_e        imm_sel;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            hazard;
   logic            load_en;
   id_ex_t          dec_d;
   id_ex_t          id_ex_q;

   assign opcode     = ir_i[6:0];
   assign rd         = ir_i[11:7];
   assign funct3     = ir_i[14:12];
   assign funct7     = ir_i[31:25];
   assign rs1_addr_o = ir_i[19:15];
   assign rs2_addr_o = ir_i[24:20];

   always_comb begin
      imm_sel = IMM_I;
      case (opcode)
         OP_STORE:        imm_sel = IMM_S;
         OP_BRANCH:       imm_sel = IMM_B;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         OP_JAL:          imm_sel = IMM_J;
         default:         imm_sel = IMM_I;
      endcase
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .ir_i  (ir_i),
      .sel_i (imm_sel),
      .imm_o (imm)
   );

   always_comb begin
      dec_d          = '0;
      dec_d.valid    = 1'b1;
      dec_d.pc       = npc_i - XLEN'(4);
      dec_d.rs1_data = rs1_data_i;
      dec_d.rs2_data = rs2_data_i;
      dec_d.imm      = imm;
      dec_d.rd       = rd;
      dec_d.funct3   = funct3;
      dec_d.alu_op   = ALU_ADD;
      uses_rs1       = 1'b0;
      uses_rs2       = 1'b0;
      case (opcode)
         OP_LUI: begin
            dec_d.alu_op      = ALU_PASS_B;
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
         end
         OP_AUIPC: begin
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
         end
         OP_JAL: begin
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
            dec_d.jump        = 1'b1;
         end
         OP_JALR: begin
            uses_rs1          = 1'b1;
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
            dec_d.jump        = 1'b1;
         end
         OP_BRANCH: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec_d.alu_op  = ALU_SUB;
            dec_d.branch  = 1'b1;
         end
         OP_LOAD: begin
            uses_rs1          = 1'b1;
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
            dec_d.mem_read    = 1'b1;
         end
         OP_STORE: begin
            uses_rs1          = 1'b1;
            uses_rs2          = 1'b1;
            dec_d.alu_src_imm = 1'b1;
            dec_d.mem_write   = 1'b1;
         end
         OP_IMM: begin
            uses_rs1          = 1'b1;
            dec_d.alu_src_imm = 1'b1;
            dec_d.reg_write   = 1'b1;
            dec_d.alu_op      = alu_from_f3(funct3, 1'b0, funct7[5]);
            // Only shift-immediates carry a funct7 field
            if (funct3 == 3'b001 && funct7 != 7'b0000000)
               dec_d.illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
               dec_d.illegal = 1'b1;
         end
         OP_REG: begin
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
            dec_d.reg_write = 1'b1;
            dec_d.alu_op    = alu_from_f3(funct3, funct7[5], funct7[5]);
            if (!(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
               dec_d.illegal = 1'b1;
         end
         OP_SYSTEM: uses_rs1 = 1'b1;
         OP_FENCE:  ;
         default:   dec_d.illegal = 1'b1;
      endcase
      if (dec_d.illegal) begin
         dec_d.alu_op      = ALU_ADD;
         dec_d.alu_src_imm = 1'b0;
         dec_d.reg_write   = 1'b0;
         dec_d.mem_read    = 1'b0;
         dec_d.mem_write   = 1'b0;
         dec_d.branch      = 1'b0;
         dec_d.jump        = 1'b0;
      end
      if (rd == 5'd0)
         dec_d.reg_write = 1'b0;
   end

   assign hazard = valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                   ((uses_rs1 & (ex_rd_i == rs1_addr_o)) |
                    (uses_rs2 & (ex_rd_i == rs2_addr_o)));

   assign load_en = ~id_ex_q.valid | ready_i;
   assign ready_o = load_en & ~hazard & ~rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_ex_q    <= '0;
         id_ex_q.pc <= RESET_PC;
      end else if (flush_i) begin
         id_ex_q.valid     <= 1'b0;
         id_ex_q.reg_write <= 1'b0;
         id_ex_q.mem_read  <= 1'b0;
         id_ex_q.mem_write <= 1'b0;
         id_ex_q.branch    <= 1'b0;
         id_ex_q.jump      <= 1'b0;
         id_ex_q.illegal   <= 1'b0;
      end else if (load_en) begin
         if (valid_i && ready_o) begin
            id_ex_q <= dec_d;
         end else if (hazard) begin
            id_ex_q.valid     <= 1'b0;
            id_ex_q.reg_write <= 1'b0;
            id_ex_q.mem_read  <= 1'b0;
            id_ex_q.mem_write <= 1'b0;
            id_ex_q.branch    <= 1'b0;
            id_ex_q.jump      <= 1'b0;
            id_ex_q.illegal   <= 1'b0;
         end else begin
            id_ex_q.valid <= 1'b0;
         end
      end
   end

   assign valid_o       = id_ex_q.valid;
   assign pc_o          = id_ex_q.pc;
   assign rs1_data_o    = id_ex_q.rs1_data;
   assign rs2_data_o    = id_ex_q.rs2_data;
   assign imm_o         = id_ex_q.imm;
   assign rd_o          = id_ex_q.rd;
   assign funct3_o      = id_ex_q.funct3;
   assign alu_op_o      = id_ex_q.alu_op;
   assign alu_src_imm_o = id_ex_q.alu_src_imm;
   assign reg_write_o   = id_ex_q.reg_write;
   assign mem_read_o    = id_ex_q.mem_read;
   assign mem_write_o   = id_ex_q.mem_write;
   assign branch_o      = id_ex_q.branch;
   assign jump_o        = id_ex_q.jump;
   assign illegal_o     = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// hazard, hold, flush and reset sequences.
module tb_id_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] ir_i, npc_i, rs1_data_i, rs2_data_i;
   logic        valid_i, ready_o, flush_i, ex_is_load_i, ready_i, valid_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_i, rd_o;
   logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
   logic [2:0]  funct3_o;
   logic [3:0]  alu_op_o;
   logic        alu_src_imm_o, reg_write_o, mem_read_o, mem_write_o;
   logic        branch_o, jump_o, illegal_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic [31:0] ir;
      logic [31:0] npc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic [6:0]  ctl; // {src_imm, reg_write, mem_read, mem_write, branch, jump, illegal}
   } vec_t;

   vec_t vecs[13];

   always #5 clk_i = ~clk_i;

   id_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .npc_i(npc_i),
      .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
      .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
      .rd_o(rd_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o),
      .alu_src_imm_o(alu_src_imm_o), .reg_write_o(reg_write_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic v);
      ir_i    = ir;
      npc_i   = npc;
      valid_i = v;
   endtask

   initial begin
      //          name      ir            npc           d1            d2            pc            imm           rd  f3 alu  ctl
      vecs[0]  = '{"addi",  32'h00500093, 32'h00000004, 32'h11111111, 32'h22222222, 32'h00000000, 32'h00000005, 1,  0, 0,  7'b1100000};
      vecs[1]  = '{"beq",   32'hFE208EE3, 32'h00000108, 32'hAAAA0001, 32'hBBBB0002, 32'h00000104, 32'hFFFFFFFC, 29, 0, 1,  7'b0000100};
      vecs[2]  = '{"add",   32'h002081B3, 32'h00000010, 32'h00000005, 32'h00000007, 32'h0000000C, 32'h00000002, 3,  0, 0,  7'b0100000};
      vecs[3]  = '{"sub",   32'h407302B3, 32'h00000014, 32'h12345678, 32'h9ABCDEF0, 32'h00000010, 32'h00000407, 5,  0, 1,  7'b0100000};
      vecs[4]  = '{"lw",    32'h00812203, 32'h00000018, 32'h00001000, 32'h00000000, 32'h00000014, 32'h00000008, 4,  2, 0,  7'b1110000};
      vecs[5]  = '{"sw",    32'hFE512C23, 32'h0000001C, 32'h00002000, 32'hDEADBEEF, 32'h00000018, 32'hFFFFFFF8, 24, 2, 0,  7'b1001000};
      vecs[6]  = '{"lui",   32'h123453B7, 32'h00000020, 32'h0, 32'h0,             32'h0000001C, 32'h12345000, 7,  5, 10, 7'b1100000};
      vecs[7]  = '{"jal",   32'h008000EF, 32'h00000024, 32'h0, 32'h0,             32'h00000020, 32'h00000008, 1,  0, 0,  7'b1100010};
      vecs[8]  = '{"srai",  32'h40335313, 32'h00000028, 32'hF0000000, 32'h0,        32'h00000024, 32'h00000403, 6,  5, 7,  7'b1100000};
      vecs[9]  = '{"ill",   32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0,             32'hFFFFFFFC, 32'hFFFFFFFF, 31, 7, 0,  7'b0000001};
      vecs[10] = '{"badf7", 32'h022081B3, 32'h00000030, 32'h0, 32'h0,             32'h0000002C, 32'h00000022, 3,  0, 0,  7'b0000001};
      vecs[11] = '{"nop",   32'h00000013, 32'h00000034, 32'h0, 32'h0,             32'h00000030, 32'h00000000, 0,  0, 0,  7'b1000000};
      vecs[12] = '{"auipc", 32'h00001117, 32'h00000038, 32'h0, 32'h0,             32'h00000034, 32'h00001000, 2,  1, 0,  7'b1100000};

      rst_i = 1'b1; drive(32'h0, 32'h0, 1'b0);
      rs1_data_i = '0; rs2_data_i = '0; flush_i = 1'b0;
      ex_rd_i = '0; ex_is_load_i = 1'b0; ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_pc", pc_o, 32'h0);
      check("rst_ctl", {alu_src_imm_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o}, 0);
      check("rst_imm", imm_o, 0);
      check("rst_ready", ready_o, 0);
      @(negedge clk_i); rst_i = 1'b0;

      // Combinational register-file addresses
      @(negedge clk_i); drive(32'hFE208EE3, 32'h4, 1'b0);
      #1;
      check("rs1_addr", rs1_addr_o, 1);
      check("rs2_addr", rs2_addr_o, 2);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk_i);
         drive(vecs[i].ir, vecs[i].npc, 1'b1);
         rs1_data_i = vecs[i].d1;
         rs2_data_i = vecs[i].d2;
         @(posedge clk_i); #1;
         check({vecs[i].name, "_valid"}, valid_o, 1);
         check({vecs[i].name, "_pc"}, pc_o, vecs[i].pc);
         check({vecs[i].name, "_imm"}, imm_o, vecs[i].imm);
         check({vecs[i].name, "_rd"}, rd_o, vecs[i].rd);
         check({vecs[i].name, "_f3"}, funct3_o, vecs[i].f3);
         check({vecs[i].name, "_alu"}, alu_op_o, vecs[i].alu);
         check({vecs[i].name, "_ctl"}, {alu_src_imm_o, reg_write_o, mem_read_o, mem_write_o,
                                       branch_o, jump_o, illegal_o}, vecs[i].ctl);
         check({vecs[i].name, "_d1"}, rs1_data_o, vecs[i].d1);
         check({vecs[i].name, "_d2"}, rs2_data_o, vecs[i].d2);
      end

      // Load-use hazard on rs1: one bubble, then the add issues
      @(negedge clk_i);
      drive(32'h002081B3, 32'h100, 1'b1);
      ex_is_load_i = 1'b1; ex_rd_i = 5'd1;
      #1 check("hz_ready", ready_o, 0);
      @(posedge clk_i); #1;
      check("hz_bubble", valid_o, 0);
      check("hz_bubble_rw", reg_write_o, 0);
      @(negedge clk_i); ex_is_load_i = 1'b0;
      #1 check("hz_release_ready", ready_o, 1);
      @(posedge clk_i); #1;
      check("hz_issue_valid", valid_o, 1);
      check("hz_issue_rd", rd_o, 3);
      check("hz_issue_pc", pc_o, 32'hFC);

      // Load into x0 never stalls
      @(negedge clk_i);
      ex_is_load_i = 1'b1; ex_rd_i = 5'd0;
      #1 check("hz_x0_ready", ready_o, 1);
      @(posedge clk_i); #1;
      check("hz_x0_valid", valid_o, 1);
      // Load into x1 does not stall LUI, which reads no registers
      @(negedge clk_i);
      drive(32'h123453B7, 32'h104, 1'b1); ex_rd_i = 5'd1;
      #1 check("hz_lui_ready", ready_o, 1);
      @(negedge clk_i); ex_is_load_i = 1'b0; ex_rd_i = 5'd0;

      // Backpressure: outputs hold for three cycles
      @(negedge clk_i); drive(32'h00500093, 32'h200, 1'b1);
      @(posedge clk_i); #1;
      check("hold_load_pc", pc_o, 32'h1FC);
      @(negedge clk_i);
      ready_i = 1'b0; drive(32'h123453B7, 32'h204, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk_i); #1;
         check("hold_ready", ready_o, 0);
         check("hold_valid", valid_o, 1);
         check("hold_pc", pc_o, 32'h1FC);
         check("hold_rd", rd_o, 1);
         check("hold_imm", imm_o, 5);
      end
      @(negedge clk_i); ready_i = 1'b1;
      #1 check("hold_release_ready", ready_o, 1);
      @(posedge clk_i); #1;
      check("hold_next_rd", rd_o, 7);
      check("hold_next_pc", pc_o, 32'h200);

      // Flush discards the accepted instruction
      @(negedge clk_i); flush_i = 1'b1; drive(32'h00500093, 32'h300, 1'b1);
      #1 check("flush_ready", ready_o, 1);
      @(posedge clk_i); #1;
      check("flush_valid", valid_o, 0);
      check("flush_rw", reg_write_o, 0);
      @(negedge clk_i); flush_i = 1'b0;
      @(posedge clk_i); #1;
      check("post_flush_valid", valid_o, 1);

      // Asynchronous reset while holding
      @(negedge clk_i); ready_i = 1'b0; valid_i = 1'b0;
      @(posedge clk_i); #2;
      check("arst_pre_valid", valid_o, 1);
      rst_i = 1'b1;
      #1;
      check("arst_valid", valid_o, 0);
      check("arst_pc", pc_o, 32'h0);
      check("arst_ready", ready_o, 0);
      @(negedge clk_i); rst_i = 1'b0; ready_i = 1'b1;
      @(posedge clk_i); #1;
      check("arst_stays_empty", valid_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
